// File: rtl/barrier_lane_arbiter_if.sv
// Lane/barrier signal bundle for barrier_lane_arbiter.
// The master side drives lane requests and barrier/car status; the slave is the arbiter.
interface barrier_lane_arbiter_if #(
    parameter int CNT_W = 4
) ();
    logic             req_in;
    logic             req_out;
    logic             car;
    logic [1:0]       bar_state;
    logic             bar_up;
    logic             gnt_in;
    logic             gnt_out;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             reject_in;
    logic             reject_out;
    logic             timeout;

    modport master (
        output req_in, req_out, car, bar_state,
        input  bar_up, gnt_in, gnt_out, occupancy, full, reject_in, reject_out, timeout
    );

    modport slave (
        input  req_in, req_out, car, bar_state,
        output bar_up, gnt_in, gnt_out, occupancy, full, reject_in, reject_out, timeout
    );
endinterface

// File: rtl/barrier_lane_arbiter.sv
// Round-robin owner of the single parking barrier: grants a lane, sequences
// raise / wait-for-car / pass / close, and tracks lot occupancy.
module barrier_lane_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int CAR_TIMEOUT = 50,
    parameter int CLEAR_HOLD  = 4
) (
    input  logic                   clk,
    input  logic                   R,
    barrier_lane_arbiter_if.slave  bus
);
    localparam int TMR_MAX = (CAR_TIMEOUT > CLEAR_HOLD) ? CAR_TIMEOUT : CLEAR_HOLD;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(CAR_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(CLEAR_HOLD - 1);
    localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
    localparam logic [1:0] BAR_DOWN = 2'b00;
    localparam logic [1:0] BAR_UP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_OPENING, S_WAIT_CAR, S_PASSING, S_CLOSING
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pend_in, r_pend_out, r_last_in;
    logic             r_bar_up, r_gnt_in, r_gnt_out, r_full;
    logic             r_rej_in, r_rej_out, r_timeout;
    logic [CNT_W-1:0] r_occ, w_occ_nxt;
    logic             w_pend_in_nxt, w_pend_out_nxt, w_last_in_nxt;
    logic             w_bar_up_nxt, w_gnt_in_nxt, w_gnt_out_nxt, w_full_nxt;

    // A pulse arriving this cycle is treated exactly like an already-latched request.
    logic w_eff_in, w_eff_out, w_idle_rdy, w_rej_in, w_rej_out;
    logic w_elig_in, w_elig_out, w_grant_in, w_grant_out, w_to, w_clear;

    assign w_eff_in    = r_pend_in  | bus.req_in;
    assign w_eff_out   = r_pend_out | bus.req_out;
    assign w_idle_rdy  = (r_state == S_IDLE) && (bus.bar_state == BAR_DOWN);
    assign w_rej_in    = w_idle_rdy & w_eff_in  & r_full;
    assign w_rej_out   = w_idle_rdy & w_eff_out & (r_occ == '0);
    assign w_elig_in   = w_idle_rdy & w_eff_in  & ~r_full;
    assign w_elig_out  = w_idle_rdy & w_eff_out & (r_occ != '0);
    // r_last_in=1 means entry was served last, so exit wins a tie.
    assign w_grant_out = w_elig_out & (~w_elig_in | r_last_in);
    assign w_grant_in  = w_elig_in & ~w_grant_out;
    assign w_to        = (r_state == S_WAIT_CAR) && !bus.car && (r_cnt == TO_LAST);
    assign w_clear     = (r_state == S_PASSING)  && !bus.car && (r_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pend_in  <= 1'b0;
            r_pend_out <= 1'b0;
            r_last_in  <= 1'b1;
            r_bar_up   <= 1'b0;
            r_gnt_in   <= 1'b0;
            r_gnt_out  <= 1'b0;
            r_occ      <= '0;
            r_full     <= 1'b0;
            r_rej_in   <= 1'b0;
            r_rej_out  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_in  <= w_pend_in_nxt;
            r_pend_out <= w_pend_out_nxt;
            r_last_in  <= w_last_in_nxt;
            r_bar_up   <= w_bar_up_nxt;
            r_gnt_in   <= w_gnt_in_nxt;
            r_gnt_out  <= w_gnt_out_nxt;
            r_occ      <= w_occ_nxt;
            r_full     <= w_full_nxt;
            r_rej_in   <= w_rej_in;
            r_rej_out  <= w_rej_out;
            r_timeout  <= w_to;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_grant_in || w_grant_out) w_state_nxt = S_OPENING;
            S_OPENING:  if (bus.bar_state == BAR_UP)   w_state_nxt = S_WAIT_CAR;
            S_WAIT_CAR: if (bus.car)                   w_state_nxt = S_PASSING;
                        else if (w_to)                 w_state_nxt = S_CLOSING;
            S_PASSING:  if (w_clear)                   w_state_nxt = S_CLOSING;
            S_CLOSING:  if (bus.bar_state == BAR_DOWN) w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == S_WAIT_CAR && !bus.car && !w_to)   w_cnt_nxt = r_cnt + 1'b1;
        if (r_state == S_PASSING && !bus.car && !w_clear) w_cnt_nxt = r_cnt + 1'b1;

        w_pend_in_nxt  = w_eff_in  & ~(w_grant_in  | w_rej_in);
        w_pend_out_nxt = w_eff_out & ~(w_grant_out | w_rej_out);
        w_last_in_nxt  = w_grant_in ? 1'b1 : (w_grant_out ? 1'b0 : r_last_in);

        w_bar_up_nxt  = (w_state_nxt == S_OPENING) || (w_state_nxt == S_WAIT_CAR) ||
                        (w_state_nxt == S_PASSING);
        w_gnt_in_nxt  = w_grant_in  | (r_gnt_in  & (w_state_nxt != S_IDLE));
        w_gnt_out_nxt = w_grant_out | (r_gnt_out & (w_state_nxt != S_IDLE));

        // Saturating guards stay even though eligibility already prevents overflow.
        w_occ_nxt = r_occ;
        if (w_clear) begin
            if (r_gnt_in && r_occ != CAP_V)   w_occ_nxt = r_occ + 1'b1;
            else if (r_gnt_out && r_occ != '0) w_occ_nxt = r_occ - 1'b1;
        end
        w_full_nxt = (w_occ_nxt == CAP_V);
    end

    assign bus.bar_up     = r_bar_up;
    assign bus.gnt_in     = r_gnt_in;
    assign bus.gnt_out    = r_gnt_out;
    assign bus.occupancy  = r_occ;
    assign bus.full       = r_full;
    assign bus.reject_in  = r_rej_in;
    assign bus.reject_out = r_rej_out;
    assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_barrier_lane_arbiter.sv
// Directed bench for barrier_lane_arbiter: grant/pass/close, round robin,
// full/empty rejects, car timeout, glitchy car sensor and mid-cycle reset.
module tb_barrier_lane_arbiter;
    logic clk = 1'b0;
    logic R   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    barrier_lane_arbiter_if #(.CNT_W(4)) bif ();

    barrier_lane_arbiter #(
        .CAPACITY(8), .CNT_W(4), .CAR_TIMEOUT(50), .CLEAR_HOLD(4)
    ) dut (
        .clk (clk),
        .R   (R),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Barrier raise, one car passing for one cycle, 4 clear cycles, barrier down.
    task automatic serve(input string tag, input int occ_after);
        bif.bar_state = 2'b01; tick();
        bif.bar_state = 2'b10; tick();
        bif.car = 1'b1; tick();
        bif.car = 1'b0; tick(); tick(); tick();
        chk({tag, "_up_hold"}, {31'd0, bif.bar_up}, 32'd1);
        tick();
        chk({tag, "_down"}, {31'd0, bif.bar_up}, 32'd0);
        chk({tag, "_occ"}, {28'd0, bif.occupancy}, occ_after);
        bif.bar_state = 2'b11; tick();
        bif.bar_state = 2'b00; tick();
        chk({tag, "_gnt_drop"}, {30'd0, bif.gnt_in, bif.gnt_out}, 32'd0);
    endtask

    task automatic pulse_in();
        bif.req_in = 1'b1; tick(); bif.req_in = 1'b0;
    endtask

    initial begin
        bif.req_in = 1'b0; bif.req_out = 1'b0; bif.car = 1'b0; bif.bar_state = 2'b00;
        tick(); tick();
        R = 1'b0;
        chk("rst_outs", {bif.bar_up, bif.gnt_in, bif.gnt_out, bif.full,
                         bif.reject_in, bif.reject_out, bif.timeout}, 32'd0);
        chk("rst_occ", {28'd0, bif.occupancy}, 32'd0);

        // Single entry with barrier modeled explicitly: 3 cycles to UP, car 5 cycles.
        pulse_in();
        chk("t1_grant", {30'd0, bif.gnt_in, bif.bar_up}, 32'd3);
        bif.bar_state = 2'b01; tick(); tick();
        bif.bar_state = 2'b10; tick();
        bif.car = 1'b1; tick(); tick(); tick(); tick(); tick();
        bif.car = 1'b0; tick(); tick(); tick();
        chk("t1_occ_pre", {28'd0, bif.occupancy}, 32'd0);
        tick();
        chk("t1_occ", {28'd0, bif.occupancy}, 32'd1);
        chk("t1_bar_dn", {31'd0, bif.bar_up}, 32'd0);
        bif.bar_state = 2'b11; tick();
        bif.bar_state = 2'b00; tick();
        chk("t1_idle", {30'd0, bif.gnt_in, bif.gnt_out}, 32'd0);

        pulse_in(); serve("e2", 2);
        pulse_in(); serve("e3", 3);

        // Simultaneous requests: exit first, entry from pending afterwards.
        bif.req_in = 1'b1; bif.req_out = 1'b1; tick();
        bif.req_in = 1'b0; bif.req_out = 1'b0;
        chk("rr_first", {30'd0, bif.gnt_in, bif.gnt_out}, 32'd1);
        chk("rr_norej", {30'd0, bif.reject_in, bif.reject_out}, 32'd0);
        serve("rr_exit", 2);
        tick();
        chk("rr_second", {30'd0, bif.gnt_in, bif.gnt_out}, 32'd2);
        chk("rr_norej2", {30'd0, bif.reject_in, bif.reject_out}, 32'd0);
        serve("rr_entry", 3);

        for (int i = 4; i <= 8; i++) begin
            pulse_in(); serve("fill", i);
        end
        chk("full_flag", {31'd0, bif.full}, 32'd1);

        pulse_in();
        chk("full_rej", {29'd0, bif.reject_in, bif.gnt_in, bif.bar_up}, 32'd4);
        tick();
        chk("full_rej_1cyc", {31'd0, bif.reject_in}, 32'd0);
        chk("full_occ", {28'd0, bif.occupancy}, 32'd8);
        chk("full_bar", {31'd0, bif.bar_up}, 32'd0);

        // Empty lot: exit request rejected.
        R = 1'b1; tick(); R = 1'b0;
        chk("rst2_occ", {27'd0, bif.full, bif.occupancy}, 32'd0);
        bif.req_out = 1'b1; tick(); bif.req_out = 1'b0;
        chk("empty_rej", {30'd0, bif.reject_out, bif.gnt_out}, 32'd2);
        tick();
        chk("empty_rej_1cyc", {30'd0, bif.reject_out, bif.gnt_out}, 32'd0);

        // No car: timeout 50 cycles after WAIT_CAR entry.
        pulse_in();
        bif.bar_state = 2'b10; tick();
        for (int i = 0; i < 49; i++) tick();
        chk("to_pre", {30'd0, bif.timeout, bif.bar_up}, 32'd1);
        tick();
        chk("to_pulse", {30'd0, bif.timeout, bif.bar_up}, 32'd2);
        chk("to_occ", {28'd0, bif.occupancy}, 32'd0);
        tick();
        chk("to_1cyc", {31'd0, bif.timeout}, 32'd0);
        bif.bar_state = 2'b00; tick();
        chk("to_idle", {30'd0, bif.gnt_in, bif.gnt_out}, 32'd0);

        // Glitching car: only 4 consecutive low cycles complete the passage.
        pulse_in();
        bif.bar_state = 2'b10; tick();
        bif.car = 1'b1; tick();
        bif.car = 1'b0; tick(); tick();
        bif.car = 1'b1; tick();
        bif.car = 1'b0; tick(); tick(); tick();
        chk("gl_hold", {27'd0, bif.bar_up, bif.occupancy}, 32'h10);
        tick();
        chk("gl_done", {27'd0, bif.bar_up, bif.occupancy}, 32'h01);
        bif.bar_state = 2'b11; tick();
        bif.bar_state = 2'b00; tick();

        // Reset in the middle of PASSING.
        pulse_in();
        bif.bar_state = 2'b10; tick();
        bif.car = 1'b1; tick();
        chk("mid_pass_up", {31'd0, bif.bar_up}, 32'd1);
        R = 1'b1; tick();
        chk("mid_rst_outs", {bif.bar_up, bif.gnt_in, bif.gnt_out, bif.full,
                             bif.reject_in, bif.reject_out, bif.timeout}, 32'd0);
        chk("mid_rst_occ", {28'd0, bif.occupancy}, 32'd0);
        R = 1'b0; bif.car = 1'b0; bif.bar_state = 2'b00;
        tick();
        chk("post_rst_idle", {29'd0, bif.bar_up, bif.gnt_in, bif.gnt_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
